// File: rtl/lopd_norm_sequencer.sv
// Multi-cycle mantissa normalizer: leading-one detect, then bounded left shifts with exponent tracking.
// Optional LOPD_NORM_FASTPATH_EN: already-normalized inputs bypass DETECT and complete in the accept cycle.
module lopd_norm_sequencer #(
  parameter int SIZE_DATA  = 24,
  parameter int SIZE_LOPD  = 5,
  parameter int SIZE_EXP   = 8,
  parameter int SHIFT_STEP = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_in_ready,
  input  logic [SIZE_DATA-1:0] i_mant,
  input  logic [SIZE_EXP-1:0]  i_exp,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_mant,
  output logic [SIZE_EXP-1:0]  o_exp,
  output logic [SIZE_LOPD-1:0] o_shift_amt,
  output logic                 o_zero,
  output logic                 o_denorm
);

  localparam int CMP_W = (SIZE_EXP > SIZE_LOPD) ? SIZE_EXP : SIZE_LOPD;
  localparam logic [SIZE_LOPD-1:0] MSB_IDX = SIZE_LOPD'(SIZE_DATA - 1);
  localparam logic [SIZE_LOPD-1:0] STEP    = SIZE_LOPD'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, DETECT, SHIFT, DONE} state_t;

  state_t               state_reg;
  logic [SIZE_DATA-1:0] mant_reg;
  logic [SIZE_EXP-1:0]  exp_reg;
  logic [SIZE_LOPD-1:0] rem_reg;
  logic [SIZE_LOPD-1:0] shift_reg;
  logic                 denorm_reg;

  // Leading-one detector: the highest set bit wins because later iterations overwrite.
  logic [SIZE_LOPD-1:0] lead_pos;
  logic                 lead_zero;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < SIZE_DATA; i++) begin
      if (mant_reg[i]) lead_pos = SIZE_LOPD'(i);
    end
    lead_zero = ~|mant_reg;
  end

  // Shift budget: distance to the MSB, capped so the exponent stays at or above 1.
  logic [SIZE_LOPD-1:0] need;
  logic [CMP_W-1:0]     need_c;
  logic [CMP_W-1:0]     allowed_c;
  logic [CMP_W-1:0]     rem_c;
  logic [SIZE_LOPD-1:0] rem_init;
  logic                 denorm_calc;

  always_comb begin
    need        = MSB_IDX - lead_pos;
    need_c      = CMP_W'(need);
    allowed_c   = (exp_reg != '0) ? CMP_W'(exp_reg - 1'b1) : '0;
    denorm_calc = (need_c > allowed_c);
    rem_c       = denorm_calc ? allowed_c : need_c;
    rem_init    = SIZE_LOPD'(rem_c);
  end

  logic [SIZE_LOPD-1:0] step;
  logic [SIZE_DATA-1:0] mant_shifted;
  logic [SIZE_EXP-1:0]  exp_shifted;
  logic [SIZE_LOPD-1:0] shift_acc;

  always_comb begin
    step         = (rem_reg > STEP) ? STEP : rem_reg;
    mant_shifted = mant_reg << step;
    exp_shifted  = exp_reg - SIZE_EXP'(step);
    shift_acc    = shift_reg + step;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      mant_reg    <= '0;
      exp_reg     <= '0;
      rem_reg     <= '0;
      shift_reg   <= '0;
      denorm_reg  <= 1'b0;
      o_in_ready  <= 1'b1;
      o_valid     <= 1'b0;
      o_mant      <= '0;
      o_exp       <= '0;
      o_shift_amt <= '0;
      o_zero      <= 1'b0;
      o_denorm    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            mant_reg   <= i_mant;
            exp_reg    <= i_exp;
            rem_reg    <= '0;
            shift_reg  <= '0;
            denorm_reg <= 1'b0;
            o_in_ready <= 1'b0;
`ifdef LOPD_NORM_FASTPATH_EN
            if (i_mant[SIZE_DATA-1]) begin
              o_mant      <= i_mant;
              o_exp       <= i_exp;
              o_shift_amt <= '0;
              o_zero      <= 1'b0;
              o_denorm    <= 1'b0;
              o_valid     <= 1'b1;
              state_reg   <= DONE;
            end else begin
              state_reg <= DETECT;
            end
`else
            state_reg <= DETECT;
`endif
          end
        end

        DETECT: begin
          if (lead_zero) begin
            o_mant      <= '0;
            o_exp       <= '0;
            o_shift_amt <= '0;
            o_zero      <= 1'b1;
            o_denorm    <= 1'b0;
            o_valid     <= 1'b1;
            state_reg   <= DONE;
          end else if (rem_init == '0) begin
            o_mant      <= mant_reg;
            o_exp       <= exp_reg;
            o_shift_amt <= '0;
            o_zero      <= 1'b0;
            o_denorm    <= denorm_calc;
            o_valid     <= 1'b1;
            state_reg   <= DONE;
          end else begin
            rem_reg    <= rem_init;
            denorm_reg <= denorm_calc;
            state_reg  <= SHIFT;
          end
        end

        SHIFT: begin
          mant_reg  <= mant_shifted;
          exp_reg   <= exp_shifted;
          rem_reg   <= rem_reg - step;
          shift_reg <= shift_acc;
          // Final step publishes the shifted values directly so DONE needs no extra cycle.
          if (rem_reg == step) begin
            o_mant      <= mant_shifted;
            o_exp       <= exp_shifted;
            o_shift_amt <= shift_acc;
            o_zero      <= 1'b0;
            o_denorm    <= denorm_reg;
            o_valid     <= 1'b1;
            state_reg   <= DONE;
          end
        end

        DONE: begin
          if (i_ready) begin
            o_valid    <= 1'b0;
            o_in_ready <= 1'b1;
            state_reg  <= IDLE;
          end
        end

        default: begin
          state_reg  <= IDLE;
          o_valid    <= 1'b0;
          o_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lopd_norm_sequencer.sv
// Self-checking bench for lopd_norm_sequencer: directed cases plus random transactions against an arithmetic model.
module tb_lopd_norm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_mant;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic [4:0]  out_shift;
  logic        out_zero;
  logic        out_denorm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lopd_norm_sequencer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (in_valid),
    .o_in_ready  (in_ready),
    .i_mant      (in_mant),
    .i_exp       (in_exp),
    .o_valid     (out_valid),
    .i_ready     (out_ready),
    .o_mant      (out_mant),
    .o_exp       (out_exp),
    .o_shift_amt (out_shift),
    .o_zero      (out_zero),
    .o_denorm    (out_denorm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: count left shifts to bring the MSB to 1, clamp by exponent headroom, then latency.
  task automatic model(input logic [23:0] m, input logic [7:0] e,
                       output logic [23:0] em, output logic [7:0] ee, output logic [4:0] es,
                       output logic ez, output logic ed, output int lat);
    int need, allowed, s;
    logic [23:0] t;
    need = 0;
    t = m;
    if (m != 0) begin
      while (t[23] == 1'b0) begin
        t = t << 1;
        need++;
      end
    end
    allowed = (e > 0) ? int'(e) - 1 : 0;
    s = (need < allowed) ? need : allowed;
    if (m == 0) begin
      em = 0; ee = 0; es = 0; ez = 1'b1; ed = 1'b0; lat = 1;
    end else begin
      em = m << s;
      ee = 8'(int'(e) - s);
      es = 5'(s);
      ez = 1'b0;
      ed = (need > allowed);
      lat = 1 + (s + 7) / 8;
`ifdef LOPD_NORM_FASTPATH_EN
      if (m[23]) lat = 0;
`endif
    end
  endtask

  // Accepts one input, measures latency to o_valid, checks result; leaves it pending in DONE.
  task automatic issue(input string tag, input logic [23:0] m, input logic [7:0] e);
    logic [23:0] em;
    logic [7:0]  ee;
    logic [4:0]  es;
    logic        ez, ed;
    int          lat, wait_cnt;
    model(m, e, em, ee, es, ez, ed, lat);
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    tick();
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    check({tag, ".latency"}, 32'(wait_cnt), 32'(lat));
    check({tag, ".mant"},   32'(out_mant),   32'(em));
    check({tag, ".exp"},    32'(out_exp),    32'(ee));
    check({tag, ".shift"},  32'(out_shift),  32'(es));
    check({tag, ".zero"},   32'(out_zero),   32'(ez));
    check({tag, ".denorm"}, 32'(out_denorm), 32'(ed));
    $display("txn %s mant=%06h exp=%02h -> mant=%06h exp=%02h shift=%0d zero=%0d denorm=%0d lat=%0d",
             tag, m, e, out_mant, out_exp, out_shift, out_zero, out_denorm, wait_cnt);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [23:0] hold_mant;
    logic [7:0]  hold_exp;
    logic [31:0] r;
    logic [23:0] rm;
    logic [7:0]  re;

    rst = 1'b1;
    in_valid = 1'b0;
    in_mant = '0;
    in_exp = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.mant", 32'(out_mant), 32'd0);
    check("rst.exp", 32'(out_exp), 32'd0);
    check("rst.shift", 32'(out_shift), 32'd0);
    check("rst.flags", {30'd0, out_zero, out_denorm}, 32'd0);

    issue("norm", 24'h800000, 8'h80);
    drain("norm");
    issue("one", 24'h000001, 8'h80);
    check("one.exp_abs", 32'(out_exp), 32'h69);
    drain("one");
    issue("zero", 24'h000000, 8'h55);
    drain("zero");
    issue("clamp", 24'h000100, 8'h05);
    check("clamp.mant_abs", 32'(out_mant), 32'h001000);
    drain("clamp");
    issue("exp0", 24'h000100, 8'h00);
    drain("exp0");
    issue("exp1", 24'h400000, 8'h01);
    drain("exp1");

    // Stall: result pending while new data is offered
    issue("stall", 24'h00F000, 8'h40);
    hold_mant = out_mant;
    hold_exp  = out_exp;
    in_valid = 1'b1;
    in_mant  = 24'h123456;
    in_exp   = 8'h22;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall.valid", 32'(out_valid), 32'd1);
      check("stall.in_ready", 32'(in_ready), 32'd0);
      check("stall.mant", 32'(out_mant), 32'(hold_mant));
      check("stall.exp", 32'(out_exp), 32'(hold_exp));
    end
    in_valid = 1'b0;
    drain("stall");
    tick();
    check("stall.no_accept", 32'(in_ready), 32'd1);

    // Reset during SHIFT
    in_valid = 1'b1;
    in_mant  = 24'h000001;
    in_exp   = 8'h80;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.mant", 32'(out_mant), 32'd0);
    check("midrst.exp", 32'(out_exp), 32'd0);
    check("midrst.shift", 32'(out_shift), 32'd0);
    check("midrst.flags", {30'd0, out_zero, out_denorm}, 32'd0);
    repeat (4) begin
      tick();
      check("midrst.quiet", 32'(out_valid), 32'd0);
    end
    issue("after_rst", 24'h400000, 8'h10);
    check("after_rst.mant_abs", 32'(out_mant), 32'h800000);
    check("after_rst.exp_abs", 32'(out_exp), 32'h0F);
    drain("after_rst");

    for (int n = 0; n < 40; n++) begin
      r  = $urandom;
      rm = 24'(r >> $urandom_range(0, 31));
      re = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 25)) : 8'($urandom);
      issue($sformatf("rnd%0d", n), rm, re);
      drain($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
